if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I pipeline. It owns the PC, issues requests to instruction memory over a req/ready handshake, and feeds the decode stage. It also applies stall (from the hazard unit) and flush/redirect (from branch/jump resolution in EX). pc_o drives the top-level pc_out.

---
 rtl/if_stage.sv | 142 ++++++++++++++
 tb/tb_if_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I pipeline.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        misalign_o,
  output logic [31:0] fetched_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] stall_cnt_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   pending_pc_q;
  logic [XLEN-1:0]   ifid_pc_q;
  logic [XLEN-1:0]   ifid_instr_q;
  logic              ifid_valid_q;
  logic              misalign_q;
  logic [XLEN-1:0]   redirect_pc_d;
  logic              fetch_load;

  assign redirect_pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign fetch_load    = (state_q == FETCH) && !flush_i && !stall_i && imem_ready_i;

  // Fetch FSM, PC and IF/ID register; flush beats stall beats a normal fetch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      pending_pc_q <= '0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      misalign_q <= flush_i && (redirect_pc_i[1:0] != 2'b00);
      unique case (state_q)
        BOOT: begin
          state_q <= FETCH;
          if (flush_i) begin
            pc_q         <= redirect_pc_d;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end
        end
        FETCH: begin
          if (flush_i) begin
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            if (imem_ready_i) begin
              pc_q <= redirect_pc_d;
            end else begin
              // Outstanding request must complete at the old address first.
              pending_pc_q <= redirect_pc_d;
              state_q      <= DISCARD;
            end
          end else if (!stall_i) begin
            if (imem_ready_i) begin
              ifid_pc_q    <= pc_q;
              ifid_instr_q <= imem_rdata_i;
              ifid_valid_q <= 1'b1;
              pc_q         <= pc_q + XLEN'(4);
            end else begin
              ifid_instr_q <= NOP_INSTR;
              ifid_valid_q <= 1'b0;
            end
          end
        end
        DISCARD: begin
          if (flush_i) pending_pc_q <= redirect_pc_d;
          if (imem_ready_i) begin
            pc_q    <= flush_i ? redirect_pc_d : pending_pc_q;
            state_q <= FETCH;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_req_o   = (state_q != BOOT);
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc_q + XLEN'(4);
  assign ifid_instr_o = ifid_instr_q;
  assign ifid_valid_o = ifid_valid_q;
  assign misalign_o   = misalign_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] fetched_cnt_q;
  logic [XLEN-1:0] flush_cnt_q;
  logic [XLEN-1:0] stall_cnt_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_cnt_q <= '0;
      flush_cnt_q   <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (fetch_load) fetched_cnt_q <= fetched_cnt_q + XLEN'(1);
      if (flush_i)    flush_cnt_q   <= flush_cnt_q + XLEN'(1);
      if (stall_i && !flush_i && (state_q == FETCH)) stall_cnt_q <= stall_cnt_q + XLEN'(1);
    end
  end

  assign fetched_cnt_o = fetched_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign stall_cnt_o   = stall_cnt_q;
`else
  logic unused_fetch_load;
  assign unused_fetch_load = fetch_load;
  assign fetched_cnt_o = '0;
  assign flush_cnt_o   = '0;
  assign stall_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a cycle-level fetch-stream model predicts each cycle's outputs.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_ready_i = 1'b0;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o, ifid_pc_o, ifid_pc4_o, ifid_instr_o;
  logic        ifid_valid_o, misalign_o;
  logic [31:0] fetched_cnt_o, flush_cnt_o, stall_cnt_o;

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata_i = mem(imem_addr_o);

  if_stage dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_rdata_i(imem_rdata_i), .pc_o(pc_o),
    .ifid_pc_o(ifid_pc_o), .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o),
    .ifid_valid_o(ifid_valid_o), .misalign_o(misalign_o), .fetched_cnt_o(fetched_cnt_o),
    .flush_cnt_o(flush_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ipc, iins, fc, flc, sc;
    logic        req, ival, mis;
  } snap_t;
  snap_t sq[$];

  // Reference model state: what the fetch stream should look like.
  bit          m_boot, m_drain;
  logic [31:0] m_pc, m_pend, m_ipc, m_iins, m_fc, m_flc, m_sc;
  logic        m_ival, m_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model(input bit r, st, fl, input logic [31:0] rd, input bit rdy);
    logic [31:0] tgt;
    tgt = rd & 32'hFFFF_FFFC;
    if (r) begin
      m_boot = 1; m_drain = 0; m_pc = RST_PC; m_pend = 0;
      m_ipc = 0; m_iins = NOP; m_ival = 0; m_mis = 0;
      m_fc = 0; m_flc = 0; m_sc = 0;
      return;
    end
    m_mis = fl && (rd[1:0] != 2'b00);
    if (fl) m_flc++;
    if (m_boot) begin
      m_boot = 0;
    end else if (m_drain) begin
      if (fl) m_pend = tgt;
      if (rdy) begin m_pc = m_pend; m_drain = 0; end
    end else if (fl) begin
      m_iins = NOP; m_ival = 0;
      if (rdy) m_pc = tgt;
      else begin m_pend = tgt; m_drain = 1; end
    end else if (st) begin
      m_sc++;
    end else if (rdy) begin
      m_ipc = m_pc; m_iins = mem(m_pc); m_ival = 1; m_pc = m_pc + 32'd4; m_fc++;
    end else begin
      m_iins = NOP; m_ival = 0;
    end
  endfunction

  task automatic step(input bit r, st, fl, input logic [31:0] rd, input bit rdy);
    snap_t s;
    bit    f;
    @(negedge clk); #1;
    f = fl && !m_boot;
    reset = r; stall_i = st; flush_i = f; redirect_pc_i = rd; imem_ready_i = rdy;
    model(r, st, f, rd, rdy);
    s.pc = m_pc; s.req = !m_boot; s.ipc = m_ipc; s.iins = m_iins; s.ival = m_ival;
    s.mis = m_mis;
    s.fc = PERF ? m_fc : 32'd0; s.flc = PERF ? m_flc : 32'd0; s.sc = PERF ? m_sc : 32'd0;
    sq.push_back(s);
  endtask

  // Monitor: each negedge the state produced by the last edge is compared.
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (sq.size() > 0) begin
        s = sq.pop_front();
        chk("pc", pc_o, s.pc);
        chk("req", 32'(imem_req_o), 32'(s.req));
        chk("addr", imem_addr_o, s.pc);
        chk("ifid_pc", ifid_pc_o, s.ipc);
        chk("ifid_pc4", ifid_pc4_o, s.ipc + 32'd4);
        chk("ifid_instr", ifid_instr_o, s.iins);
        chk("ifid_valid", 32'(ifid_valid_o), 32'(s.ival));
        chk("misalign", 32'(misalign_o), 32'(s.mis));
        chk("fetched_cnt", fetched_cnt_o, s.fc);
        chk("flush_cnt", flush_cnt_o, s.flc);
        chk("stall_cnt", stall_cnt_o, s.sc);
      end
    end
  end

  initial begin
    m_boot = 1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h24, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h80, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 1, 1, 32'h26, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'hFFFF_FFF9, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rd;
      rd = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                      : 32'($urandom_range(0, 511));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 7) == 0, rd, $urandom_range(0, 9) < 7);
    end
    @(negedge clk); #2;
    chk("scoreboard_drained", 32'(sq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
